// File: rtl/riscv_pkg.sv
// Shared constants and helpers for the RISC-V writeback collector.
// Holds the rd field position, the register index width and the source priority.
package riscv_pkg;

    localparam int RD_LSB    = 7;
    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_DIV  = 2'd2,
        SRC_MUL  = 2'd3
    } src_e;

    // True when two or more of the three result sources are valid together.
    function automatic logic multi_valid(input logic a_v, input logic b_v, input logic c_v);
        return (a_v & b_v) | (a_v & c_v) | (b_v & c_v);
    endfunction

    function automatic src_e pick_src(input logic alu_v, input logic mul_v, input logic div_v);
        if (mul_v) begin
            return SRC_MUL;
        end else if (div_v) begin
            return SRC_DIV;
        end else if (alu_v) begin
            return SRC_ALU;
        end else begin
            return SRC_NONE;
        end
    endfunction

endpackage

// File: rtl/riscv_wb_skid.sv
// Two-entry FIFO holding writeback payloads; the head is visible on data_out.
// Storage is left unreset: only count and pointers define which entries are live.
module riscv_wb_skid #(
    parameter int W = 37
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         flush,
    input  logic         push,
    input  logic         pop_en,
    input  logic [W-1:0] data_in,
    output logic         empty,
    output logic         full,
    output logic [W-1:0] data_out
);

    logic [1:0]   count_q, count_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [2];
    logic         push_s, pop_s;

    assign empty    = (count_q == 2'd0);
    assign full     = (count_q == 2'd2);
    assign push_s   = push & ~full;
    assign pop_s    = ~empty & pop_en;
    assign data_out = mem_q[rd_ptr_q];

    // Next-state for occupancy and pointers; flush beats any push or pop.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Occupancy and pointer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage write.
    always_ff @(posedge clk) begin
        if (push_s && !flush) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: rtl/riscv_wb_collect.sv
// Collects ALU/MUL/DIV results into one writeback stream through a 2-entry buffer.
// Picks one source per cycle (mul > div > alu) and flags same-cycle collisions.
module riscv_wb_collect
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int INSTR_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic [INSTR_SIZE-1:0] ex_instr,
    input  logic                  alu_bubble,
    input  logic [XLEN-1:0]       alu_r,
    input  logic                  mul_bubble,
    input  logic [XLEN-1:0]       mul_r,
    input  logic                  div_bubble,
    input  logic [XLEN-1:0]       div_r,
    input  logic                  wb_stall,
    output logic                  ex_stall,
    output logic                  wb_bubble,
    output logic [XLEN-1:0]       wb_r,
    output logic [4:0]            wb_dst,
    output logic                  wb_we,
    output logic                  collision
);

    localparam int PW = XLEN + REG_IDX_W;

    src_e                 src_s;
    logic [XLEN-1:0]      result_s;
    logic                 push_s;
    logic                 empty_s;
    logic                 full_s;
    logic [PW-1:0]        head_s;
    logic                 collision_q, collision_d;
    logic [REG_IDX_W-1:0] rd_s;
    logic                 unused_instr_s;

    assign rd_s           = ex_instr[RD_LSB +: REG_IDX_W];
    assign unused_instr_s = ^{ex_instr[INSTR_SIZE-1:RD_LSB+REG_IDX_W], ex_instr[RD_LSB-1:0]};
    assign src_s          = pick_src(~alu_bubble, ~mul_bubble, ~div_bubble);
    assign push_s         = (src_s != SRC_NONE);

    // Result mux for the winning source.
    always_comb begin
        result_s = {XLEN{1'b0}};
        case (src_s)
            SRC_MUL: result_s = mul_r;
            SRC_DIV: result_s = div_r;
            SRC_ALU: result_s = alu_r;
            default: result_s = {XLEN{1'b0}};
        endcase
    end

    riscv_wb_skid #(.W(PW)) u_skid (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (flush),
        .push     (push_s),
        .pop_en   (~wb_stall),
        .data_in  ({result_s, rd_s}),
        .empty    (empty_s),
        .full     (full_s),
        .data_out (head_s)
    );

    // A collision only counts when the buffer could have accepted the push.
    always_comb begin
        if (flush) begin
            collision_d = 1'b0;
        end else begin
            collision_d = multi_valid(~alu_bubble, ~mul_bubble, ~div_bubble) & ~full_s;
        end
    end

    // Collision pulse register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= collision_d;
        end
    end

    assign ex_stall  = full_s;
    assign wb_bubble = empty_s;
    assign wb_r      = head_s[PW-1:REG_IDX_W];
    assign wb_dst    = head_s[REG_IDX_W-1:0];
    assign wb_we     = ~empty_s & (head_s[REG_IDX_W-1:0] != {REG_IDX_W{1'b0}});
    assign collision = collision_q;

endmodule

// File: tb/tb_riscv_wb_collect.sv
// Directed bench for riscv_wb_collect: a queue scoreboard tracks expected FIFO contents
// alongside constant checks for each scenario.
module tb_riscv_wb_collect;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic [31:0] ex_instr;
    logic        alu_bubble, mul_bubble, div_bubble;
    logic [31:0] alu_r, mul_r, div_r;
    logic        wb_stall;
    logic        ex_stall, wb_bubble, wb_we, collision;
    logic [31:0] wb_r;
    logic [4:0]  wb_dst;

    typedef struct {
        logic [31:0] r;
        logic [4:0]  d;
    } ent_t;

    ent_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    riscv_wb_collect #(.XLEN(32), .INSTR_SIZE(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .ex_instr   (ex_instr),
        .alu_bubble (alu_bubble),
        .alu_r      (alu_r),
        .mul_bubble (mul_bubble),
        .mul_r      (mul_r),
        .div_bubble (div_bubble),
        .div_r      (div_r),
        .wb_stall   (wb_stall),
        .ex_stall   (ex_stall),
        .wb_bubble  (wb_bubble),
        .wb_r       (wb_r),
        .wb_dst     (wb_dst),
        .wb_we      (wb_we),
        .collision  (collision)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        alu_bubble = 1'b1;
        mul_bubble = 1'b1;
        div_bubble = 1'b1;
        flush      = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] rd);
        ex_instr = {20'h00000, rd, 7'h33};
    endtask

    task automatic check_state();
        chk("wb_bubble", {63'd0, wb_bubble}, {63'd0, sb.size() == 0});
        chk("ex_stall", {63'd0, ex_stall}, {63'd0, sb.size() == 2});
        if (sb.size() > 0) begin
            chk("wb_r", {32'd0, wb_r}, {32'd0, sb[0].r});
            chk("wb_dst", {59'd0, wb_dst}, {59'd0, sb[0].d});
            chk("wb_we", {63'd0, wb_we}, {63'd0, sb[0].d != 5'd0});
        end
    endtask

    // One clock: predict, advance the scoreboard, then check on the falling edge.
    task automatic step();
        int   sz;
        int   nv;
        logic acc, popd, exp_coll;
        ent_t e;
        sz   = sb.size();
        nv   = int'(!alu_bubble) + int'(!mul_bubble) + int'(!div_bubble);
        acc  = (nv > 0) && (sz < 2) && !flush;
        popd = (sz > 0) && !wb_stall && !flush;
        exp_coll = (nv > 1) && (sz < 2) && !flush;
        e.d = ex_instr[11:7];
        e.r = !mul_bubble ? mul_r : (!div_bubble ? div_r : alu_r);
        @(posedge clk);
        if (flush) begin
            sb.delete();
        end else begin
            if (popd) sb.pop_front();
            if (acc) sb.push_back(e);
        end
        @(negedge clk);
        chk("collision", {63'd0, collision}, {63'd0, exp_coll});
        check_state();
    endtask

    initial begin
        rstn = 1'b0; wb_stall = 1'b0; ex_instr = 32'd0;
        alu_r = 32'd0; mul_r = 32'd0; div_r = 32'd0;
        idle();
        repeat (2) @(negedge clk);
        chk("rst_wb_bubble", {63'd0, wb_bubble}, 64'd1);
        chk("rst_ex_stall", {63'd0, ex_stall}, 64'd0);
        chk("rst_wb_we", {63'd0, wb_we}, 64'd0);
        chk("rst_collision", {63'd0, collision}, 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Case 1: single multiplier result
        mul_bubble = 1'b0; mul_r = 32'h6; set_rd(5'd5);
        step();
        chk("c1_wb_r", {32'd0, wb_r}, 64'h6);
        chk("c1_wb_dst", {59'd0, wb_dst}, 64'd5);
        chk("c1_wb_we", {63'd0, wb_we}, 64'd1);
        idle();
        step();
        chk("c1_drain", {63'd0, wb_bubble}, 64'd1);

        // Case 2: two entries under wb_stall, then drain in order
        wb_stall = 1'b1;
        alu_bubble = 1'b0; alu_r = 32'h11; set_rd(5'd3);
        step();
        alu_r = 32'h22; set_rd(5'd4);
        step();
        chk("c2_full", {63'd0, ex_stall}, 64'd1);
        chk("c2_head0", {32'd0, wb_r}, 64'h11);
        idle(); wb_stall = 1'b0;
        step();
        chk("c2_head1", {32'd0, wb_r}, 64'h22);
        chk("c2_unstall", {63'd0, ex_stall}, 64'd0);
        step();

        // Case 3: ALU/MUL collision
        alu_bubble = 1'b0; alu_r = 32'hA; mul_bubble = 1'b0; mul_r = 32'hB; set_rd(5'd6);
        step();
        chk("c3_wb_r", {32'd0, wb_r}, 64'hB);
        chk("c3_coll", {63'd0, collision}, 64'd1);
        idle();
        step();
        chk("c3_coll_pulse", {63'd0, collision}, 64'd0);

        // Sources ignored while full: no push, no collision
        wb_stall = 1'b1;
        alu_bubble = 1'b0; alu_r = 32'h1; set_rd(5'd1);
        step();
        alu_r = 32'h2; set_rd(5'd2);
        step();
        alu_r = 32'hEE; mul_bubble = 1'b0; mul_r = 32'hFF;
        step();
        chk("full_no_coll", {63'd0, collision}, 64'd0);
        chk("full_head", {32'd0, wb_r}, 64'h1);

        // Case 4: flush with a simultaneous push
        idle(); flush = 1'b1; alu_bubble = 1'b0; alu_r = 32'h33;
        step();
        chk("c4_bubble", {63'd0, wb_bubble}, 64'd1);
        idle();
        step();
        chk("c4_no_33", {63'd0, wb_bubble}, 64'd1);

        // wb_stall on empty buffer has no effect
        step();
        wb_stall = 1'b0;

        // Case 5: push and pop together at count==1
        alu_bubble = 1'b0; alu_r = 32'h55; set_rd(5'd7);
        step();
        idle(); div_bubble = 1'b0; div_r = 32'h44; set_rd(5'd8);
        step();
        chk("c5_head", {32'd0, wb_r}, 64'h44);
        chk("c5_count1", {62'd0, ex_stall, wb_bubble}, 64'd0);
        idle();
        step();

        // Case 6: rd==0 entry, then async reset while full
        wb_stall = 1'b1;
        alu_bubble = 1'b0; alu_r = 32'h77; set_rd(5'd0);
        step();
        chk("c6_we0", {63'd0, wb_we}, 64'd0);
        chk("c6_valid", {63'd0, wb_bubble}, 64'd0);
        alu_r = 32'h78; set_rd(5'd9);
        step();
        idle();
        #2 rstn = 1'b0;
        #1;
        chk("c6_async_bubble", {63'd0, wb_bubble}, 64'd1);
        chk("c6_async_stall", {63'd0, ex_stall}, 64'd0);
        chk("c6_async_we", {63'd0, wb_we}, 64'd0);
        sb.delete();
        @(negedge clk);
        rstn = 1'b1; wb_stall = 1'b0;
        alu_bubble = 1'b0; alu_r = 32'h99; set_rd(5'd10);
        step();
        chk("post_rst_wb_r", {32'd0, wb_r}, 64'h99);
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
